// File: rtl/l1_streamer.sv
// Streams NWORDS layer-1 memory words from BASE into a small output FIFO.
// The read strobe is throttled by FIFO room, and the block keeps a running sum of accepted words.
module l1_streamer #(
  parameter int unsigned DW     = 20,
  parameter int unsigned AW     = 12,
  parameter int unsigned NWORDS = 1024,
  parameter int unsigned BASE   = 0,
  parameter int unsigned DEPTH  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic [2:0]    csel,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic [29:0]   sum
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW = $clog2(DEPTH + 1);
  localparam int unsigned CW = $clog2(NWORDS + 1);
  localparam int unsigned SW = 30;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]    state, state_nx;
  logic [CW-1:0] issued, issued_nx;
  logic [CW-1:0] xfer;
  logic [OW-1:0] occ, occ_nx;
  logic [PW-1:0] wptr, rptr;
  logic [DW-1:0] mem [DEPTH];
  logic          inflight;
  logic          crd_nx;
  logic          go, fire;

  assign go      = (state == IDLE) && start && !done;
  assign m_valid = (occ != '0);
  assign fire    = m_valid && m_ready;
  assign m_data  = m_valid ? mem[rptr] : '0;
  assign m_last  = m_valid && (xfer == CW'(NWORDS - 1));

  // Next state; the next read strobe looks ahead at next-cycle occupancy plus this cycle's read.
  always_comb begin
    state_nx  = state;
    issued_nx = issued + CW'(crd);
    occ_nx    = occ + OW'(inflight) - OW'(fire);
    crd_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          state_nx  = READ;
          issued_nx = '0;
        end
      end
      READ:    if (crd && issued == CW'(NWORDS - 1)) state_nx = DRAIN;
      DRAIN:   if (fire && m_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (state_nx == READ && issued_nx < CW'(NWORDS) &&
        ((OW + 1)'(occ_nx) + (OW + 1)'(crd)) < (OW + 1)'(DEPTH))
      crd_nx = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      crd      <= 1'b0;
      csel     <= 3'd0;
      caddr_rd <= AW'(BASE);
      issued   <= '0;
      xfer     <= '0;
      occ      <= '0;
      wptr     <= '0;
      rptr     <= '0;
      inflight <= 1'b0;
      sum      <= '0;
    end else begin
      state    <= state_nx;
      busy     <= (state_nx != IDLE);
      done     <= fire && m_last;
      crd      <= crd_nx;
      csel     <= crd_nx ? 3'd3 : 3'd0;
      issued   <= issued_nx;
      occ      <= occ_nx;
      inflight <= crd;
      if (go)       caddr_rd <= AW'(BASE);
      else if (crd) caddr_rd <= caddr_rd + AW'(1);
      if (inflight) wptr <= wptr + PW'(1);
      if (fire)     rptr <= rptr + PW'(1);
      if (go)        xfer <= '0;
      else if (fire) xfer <= xfer + CW'(1);
      if (go)        sum <= '0;
      else if (fire) sum <= sum + SW'(m_data);
    end
  end

  // Read data lands one cycle after its strobe; storage needs no reset since m_data is gated.
  always_ff @(posedge clk) begin
    if (inflight) mem[wptr] <= cdata_rd;
  end

endmodule

// File: doc/l1_streamer.md
L1_STREAMER -- requirements
Module: l1_streamer

Interface
REQ-001 Parameter DW, 20, data word width; matches layer-1 memory word width.
REQ-002 Parameter AW, 12, memory address width.
REQ-003 Parameter NWORDS, 1024, words streamed per run (32x32 layer-1 map).
REQ-004 Parameter BASE, 0, first layer-1 address read.
REQ-005 Parameter DEPTH, 4, output FIFO depth (power of two, >=2).
REQ-006 clk  in  1  clock, all state updates on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  one-cycle request to stream layer 1; sampled only in IDLE.
REQ-009 busy  out  1  high while a run is in progress.
REQ-010 done  out  1  one-cycle pulse when the final word has been accepted downstream.
REQ-011 crd  out  1  memory read strobe.
REQ-012 caddr_rd  out  AW  memory read address.
REQ-013 cdata_rd  in  DW  read data, valid exactly one cycle after the crd cycle.
REQ-014 csel  out  3  memory select: 3'd3 while crd is high, 3'd0 otherwise.
REQ-015 m_valid  out  1  output stream word valid.
REQ-016 m_ready  in  1  downstream accept; transfer occurs when m_valid && m_ready.
REQ-017 m_data  out  DW  output word, head of FIFO.
REQ-018 m_last  out  1  high with the NWORDS-th word only.
REQ-019 sum  out  30  unsigned sum of all words transferred in the current or last run.

Function
REQ-020 FSM states IDLE, READ, DRAIN: IDLE->READ on start; READ->DRAIN in the cycle after the NWORDS-th read is issued; DRAIN->IDLE on the transfer with m_last.
REQ-021 On IDLE->READ: clear address counter to 0, sum to 0, issued/transferred counters to 0; busy rises on the next edge.
REQ-022 caddr_rd = BASE + issue count; it holds its value when crd is low.
REQ-023 crd is high in READ only when (FIFO occupancy + reads in flight) < DEPTH; reads in flight is at most 1.
REQ-024 The read issued in cycle t is written into the FIFO at the edge ending cycle t+1; there is no other write path.
REQ-025 FIFO never overflows; a write while full is a design error that the bench flags.
REQ-026 Simultaneous FIFO write and transfer in one cycle leaves occupancy unchanged and preserves word order.
REQ-027 m_valid = FIFO not empty; m_data and m_last hold stable while m_valid && !m_ready.
REQ-028 Each transferred word is tagged with its sequence index; m_last is high when the index equals NWORDS-1.
REQ-029 sum accumulates m_data, zero-extended, on every transfer; no wrap is possible (NWORDS*(2^DW-1) < 2^30 at default parameters).
REQ-030 done pulses in the cycle after the m_last transfer, busy falls on the same edge, and the FSM is in IDLE.
REQ-031 A start received while not in IDLE is ignored; a start in the same cycle as done is ignored.
REQ-032 With m_ready held high, throughput is 1 word/cycle after a 2-cycle start-up: first m_valid at cycle 3 after start, final transfer at cycle NWORDS+2.

Reset
REQ-033 Reset, asynchronous at any time including mid-run, returns the block to IDLE with FIFO empty and in-flight read discarded.
REQ-034 Reset values: busy=0, done=0, crd=0, caddr_rd=BASE, csel=0, m_valid=0, m_data=0, m_last=0, sum=0.
REQ-035 After reset deasserts, no read or stream activity occurs until a new start.

Verification
REQ-036 Memory preloaded with word[i]=i, m_ready=1, start pulse -> 1024 transfers in order 0..1023, m_last only on 1023, sum=523776, done one cycle later, 1026 cycles from start to final transfer.
REQ-037 m_ready=0 for 20 cycles after start -> exactly 4 reads issued (addresses 0..3), crd low afterwards, m_data=0 stable; on release, order is preserved with no loss or duplication.
REQ-038 Random m_ready (50%) with word[i]=1023-i -> scoreboard matches all 1024 words, FIFO never overflows, crd never high when occupancy+inflight=4.
REQ-039 Reset asserted at transfer 500 -> all outputs at reset values within the same cycle, a new start runs a full 1024-word stream from address 0 with sum recomputed.
REQ-040 start pulsed again at transfer 10 and in the done cycle -> both ignored; a single done pulse and exactly 1024 transfers.
REQ-041 All words 20'hFFFFF -> sum=30'h3FFFFC00, csel=3 exactly on the 1024 crd cycles, 0 elsewhere.
